// File: rtl/alarm_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// alarm_pkg
// Shared definitions for the alarm sequencer slice:
//   - state_t     : sequencer states (IDLE, ON, OFF, DONE)
//   - DEF_*       : default timing constants (50 MHz board clock)
//   - cnt_width   : bit width for a counter running 0..n-1 (never below 1)
//   - max2        : larger of two integers, used when two counts share a register
// ----------------------------------------------------------------------------
package alarm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int DEF_NREQ      = 4;
    localparam int DEF_TONE_HALF = 25000;    // 1 kHz tone at 50 MHz
    localparam int DEF_BEAT_DIV  = 5000000;  // 100 ms beat at 50 MHz
    localparam int DEF_ON_BEATS  = 2;
    localparam int DEF_OFF_BEATS = 1;
    localparam int DEF_BEEPS     = 3;

    // A counter spanning 0..n-1 needs $clog2(n) bits; keep at least one bit
    // so a degenerate count of 1 still yields a legal vector.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/alarm_sequencer_if.sv
// ----------------------------------------------------------------------------
// alarm_sequencer_if
// Request/grant bundle between the alarm sources and the sequencer.
//   req      : level request per requester, held until done or to abort
//   stop_all : synchronous abort / grant inhibit
//   grant    : one-hot buzzer owner, zero when idle
//   done     : one-cycle completion pulse (grant still valid that cycle)
//   busy     : sequencer is not idle
// master = alarm sources side, slave = sequencer side.
// ----------------------------------------------------------------------------
interface alarm_sequencer_if
    import alarm_pkg::*;
#(
    parameter int NREQ = DEF_NREQ
);

    logic [NREQ-1:0] req;
    logic            stop_all;
    logic [NREQ-1:0] grant;
    logic            done;
    logic            busy;

    modport master (
        output req,
        output stop_all,
        input  grant,
        input  done,
        input  busy
    );

    modport slave (
        input  req,
        input  stop_all,
        output grant,
        output done,
        output busy
    );

endinterface

// File: rtl/alarm_sequencer_rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Round-robin picker for the alarm sequencer.
//   CLK, RST_N : clock, asynchronous active-low reset
//   req        : pending requests
//   advance    : the caller is issuing a grant this cycle; remember the winner
//   gnt        : one-hot winner (combinational), zero when nothing is pending
//   any        : at least one request is pending
// The pointer holds the last granted index; the search starts one above it
// and wraps, so after reset (pointer = NREQ-1) requester 0 ranks highest.
// ----------------------------------------------------------------------------
module rr_arbiter
    import alarm_pkg::*;
#(
    parameter int NREQ = DEF_NREQ
)(
    input  logic            CLK,
    input  logic            RST_N,
    input  logic [NREQ-1:0] req,
    input  logic            advance,
    output logic [NREQ-1:0] gnt,
    output logic            any
);

    localparam int AW = cnt_width(NREQ);

    logic [AW-1:0] last_q;
    logic [AW-1:0] win;
    logic [AW-1:0] idx;
    logic          found;

    // Walk the requesters starting just after the previous winner; the first
    // pending one found takes the grant.
    always_comb begin
        gnt   = '0;
        win   = last_q;
        idx   = '0;
        found = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = AW'((int'(last_q) + i) % NREQ);
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                win      = idx;
            end
        end
    end

    assign any = |req;

    // The priority only rotates when a grant is actually handed out.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            last_q <= AW'(NREQ - 1);
        end else if (advance && any) begin
            last_q <= win;
        end
    end

endmodule

// File: rtl/alarm_sequencer.sv
// ----------------------------------------------------------------------------
// alarm_sequencer
// Shares one board buzzer between NREQ alarm sources. A round-robin winner
// is granted and hears BEEPS beeps, each ON_BEATS beats of square-wave tone
// followed by OFF_BEATS beats of silence, then a one-cycle done pulse.
//   CLK    : system clock, rising edge
//   RST_N  : asynchronous active-low reset
//   bus    : request/grant bundle (req, stop_all in; grant, done, busy out)
//   BUZZER : buzzer drive, registered
// ----------------------------------------------------------------------------
module alarm_sequencer
    import alarm_pkg::*;
#(
    parameter int NREQ      = DEF_NREQ,
    parameter int TONE_HALF = DEF_TONE_HALF,
    parameter int BEAT_DIV  = DEF_BEAT_DIV,
    parameter int ON_BEATS  = DEF_ON_BEATS,
    parameter int OFF_BEATS = DEF_OFF_BEATS,
    parameter int BEEPS     = DEF_BEEPS
)(
    input  logic              CLK,
    input  logic              RST_N,
    alarm_sequencer_if.slave  bus,
    output logic              BUZZER
);

    localparam int TW = cnt_width(TONE_HALF);
    localparam int BW = cnt_width(BEAT_DIV);
    localparam int NW = cnt_width(max2(ON_BEATS, OFF_BEATS));
    localparam int PW = cnt_width(BEEPS);

    localparam logic [TW-1:0] TONE_LAST = TW'(TONE_HALF - 1);
    localparam logic [BW-1:0] BEAT_LAST = BW'(BEAT_DIV - 1);
    localparam logic [NW-1:0] ON_LAST   = NW'(ON_BEATS - 1);
    localparam logic [NW-1:0] OFF_LAST  = NW'(OFF_BEATS - 1);
    localparam logic [PW-1:0] BEEP_LAST = PW'(BEEPS - 1);

    state_t          state;
    logic [TW-1:0]   tone_cnt;
    logic [BW-1:0]   beat_cnt;
    logic [NW-1:0]   beat_num;
    logic [PW-1:0]   beep_num;
    logic [NREQ-1:0] grant_q;
    logic            done_q;
    logic            busy_q;

    logic [NREQ-1:0] arb_gnt;
    logic            arb_any;
    logic            start;
    logic            abort;
    logic            beat_tick;

    // A grant is only decided from IDLE, and stop_all holds everyone off.
    assign start     = (state == IDLE) && !bus.stop_all && arb_any;
    // Owner let go of its request, or a global stop: leave without done.
    assign abort     = bus.stop_all || ((bus.req & grant_q) == '0);
    assign beat_tick = (beat_cnt == BEAT_LAST);

    rr_arbiter #(
        .NREQ    (NREQ)
    ) u_arb (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .req     (bus.req),
        .advance (start),
        .gnt     (arb_gnt),
        .any     (arb_any)
    );

    // Sequencer: grant in IDLE, tone/beat timing in ON and OFF, a single
    // DONE cycle for the completion pulse. Abort beats any beat transition.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= IDLE;
            grant_q  <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            BUZZER   <= 1'b0;
            tone_cnt <= '0;
            beat_cnt <= '0;
            beat_num <= '0;
            beep_num <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= ON;
                        grant_q  <= arb_gnt;
                        busy_q   <= 1'b1;
                        BUZZER   <= 1'b0;
                        tone_cnt <= '0;
                        beat_cnt <= '0;
                        beat_num <= '0;
                        beep_num <= '0;
                    end
                end

                ON, OFF: begin
                    if (abort) begin
                        state    <= IDLE;
                        grant_q  <= '0;
                        busy_q   <= 1'b0;
                        BUZZER   <= 1'b0;
                        tone_cnt <= '0;
                        beat_cnt <= '0;
                        beat_num <= '0;
                        beep_num <= '0;
                    end else begin
                        beat_cnt <= beat_tick ? '0 : beat_cnt + 1'b1;
                        if (state == ON) begin
                            if (tone_cnt == TONE_LAST) begin
                                tone_cnt <= '0;
                                BUZZER   <= ~BUZZER;
                            end else begin
                                tone_cnt <= tone_cnt + 1'b1;
                            end
                            // Leaving ON silences the buzzer and restarts
                            // the tone phase for the next beep.
                            if (beat_tick) begin
                                if (beat_num == ON_LAST) begin
                                    state    <= OFF;
                                    BUZZER   <= 1'b0;
                                    tone_cnt <= '0;
                                    beat_num <= '0;
                                end else begin
                                    beat_num <= beat_num + 1'b1;
                                end
                            end
                        end else begin
                            BUZZER <= 1'b0;
                            if (beat_tick) begin
                                if (beat_num == OFF_LAST) begin
                                    beat_num <= '0;
                                    if (beep_num == BEEP_LAST) begin
                                        state  <= DONE;
                                        done_q <= 1'b1;
                                    end else begin
                                        beep_num <= beep_num + 1'b1;
                                        state    <= ON;
                                    end
                                end else begin
                                    beat_num <= beat_num + 1'b1;
                                end
                            end
                        end
                    end
                end

                DONE: begin
                    state    <= IDLE;
                    grant_q  <= '0;
                    busy_q   <= 1'b0;
                    BUZZER   <= 1'b0;
                    tone_cnt <= '0;
                    beat_cnt <= '0;
                    beat_num <= '0;
                    beep_num <= '0;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.grant = grant_q;
    assign bus.done  = done_q;
    assign bus.busy  = busy_q;

endmodule

// File: tb/tb_alarm_sequencer.sv
// ----------------------------------------------------------------------------
// tb_alarm_sequencer
// Self-checking bench for alarm_sequencer with short timing parameters.
// Expected behaviour comes from a small model: a round-robin pointer over
// requester indices and an arithmetic formula for the beep cadence measured
// from the first granted cycle.
// ----------------------------------------------------------------------------
module tb_alarm_sequencer;

    localparam int NREQ   = 4;
    localparam int TH     = 2;
    localparam int BD     = 8;
    localparam int ONB    = 2;
    localparam int OFFB   = 1;
    localparam int NB     = 2;
    localparam int PERIOD = (ONB + OFFB) * BD;
    localparam int SEQ    = NB * PERIOD;   // cycle offset of the done pulse

    logic clk = 1'b0;
    logic rst_n;
    logic buzzer;

    int checks = 0;
    int errors = 0;
    int last_idx = NREQ - 1;

    alarm_sequencer_if #(.NREQ(NREQ)) bus ();

    alarm_sequencer #(
        .NREQ      (NREQ),
        .TONE_HALF (TH),
        .BEAT_DIV  (BD),
        .ON_BEATS  (ONB),
        .OFF_BEATS (OFFB),
        .BEEPS     (NB)
    ) dut (
        .CLK    (clk),
        .RST_N  (rst_n),
        .bus    (bus),
        .BUZZER (buzzer)
    );

    always #5 clk = ~clk;

    // Next winner: first pending requester searching upward from the one
    // after the previous winner, wrapping around.
    function automatic int rr_pick(input logic [NREQ-1:0] r);
        logic [1:0] c;
        for (int k = 1; k <= NREQ; k++) begin
            c = 2'((last_idx + k) % NREQ);
            if (r[c]) return int'(c);
        end
        return -1;
    endfunction

    // Buzzer level t cycles after the grant: each beep period starts with
    // ON_BEATS*BD cycles of a square wave of half-period TH starting low.
    function automatic logic exp_buzz(input int t);
        int p;
        if (t < 0 || t >= SEQ) return 1'b0;
        p = t % PERIOD;
        if (p >= ONB * BD) return 1'b0;
        return ((p / TH) % 2) == 1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        bus.req = '0;
        bus.stop_all = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        checks++; if (bus.grant !== 4'b0000) begin errors++; $display("[TB] FAIL reset_grant got %b want 0000", bus.grant); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b want 0", bus.done); end
        checks++; if (buzzer !== 1'b0) begin errors++; $display("[TB] FAIL reset_buzzer got %b want 0", buzzer); end
        tick();
        rst_n = 1'b1;
        last_idx = NREQ - 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (bus.grant !== 4'b0000 || bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL idle_quiet grant %b busy %b want 0000 0", bus.grant, bus.busy); end
        end
    endtask

    task automatic test_single_cadence();
        int w;
        logic [NREQ-1:0] g, eg;
        bus.req = 4'b0001;
        w = rr_pick(bus.req);
        g = 4'b0001 << w;
        last_idx = w;
        tick();
        for (int t = 0; t <= SEQ + 1; t++) begin
            eg = (t <= SEQ) ? g : 4'b0000;
            checks++; if (bus.grant !== eg) begin errors++; $display("[TB] FAIL cad_grant t=%0d got %b want %b", t, bus.grant, eg); end
            checks++; if (bus.busy !== (t <= SEQ)) begin errors++; $display("[TB] FAIL cad_busy t=%0d got %b want %b", t, bus.busy, (t <= SEQ)); end
            checks++; if (bus.done !== (t == SEQ)) begin errors++; $display("[TB] FAIL cad_done t=%0d got %b want %b", t, bus.done, (t == SEQ)); end
            checks++; if (buzzer !== exp_buzz(t)) begin errors++; $display("[TB] FAIL cad_buzzer t=%0d got %b want %b", t, buzzer, exp_buzz(t)); end
            if (t == SEQ) bus.req = '0;
            tick();
        end
    endtask

    task automatic test_rotation();
        int w;
        logic [NREQ-1:0] g, eg;
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        last_idx = NREQ - 1;
        bus.req = 4'b0110;
        w = rr_pick(bus.req);
        g = 4'b0001 << w;
        last_idx = w;
        tick();
        for (int t = 0; t <= SEQ + 1; t++) begin
            eg = (t <= SEQ) ? g : 4'b0000;
            checks++; if (bus.grant !== eg) begin errors++; $display("[TB] FAIL rot_first_grant t=%0d got %b want %b", t, bus.grant, eg); end
            if (t == SEQ) begin
                checks++; if (bus.done !== 1'b1) begin errors++; $display("[TB] FAIL rot_done got %b want 1", bus.done); end
            end
            tick();
        end
        w = rr_pick(bus.req);
        g = 4'b0001 << w;
        last_idx = w;
        checks++; if (bus.grant !== g) begin errors++; $display("[TB] FAIL rot_second_grant got %b want %b", bus.grant, g); end
        tick(); tick(); tick();
        bus.req = 4'b0010;
        tick();
        checks++; if (bus.grant !== 4'b0000 || bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL rot_drop grant %b busy %b want 0000 0", bus.grant, bus.busy); end
        w = rr_pick(bus.req);
        g = 4'b0001 << w;
        last_idx = w;
        tick();
        checks++; if (bus.grant !== g) begin errors++; $display("[TB] FAIL rot_third_grant got %b want %b", bus.grant, g); end
        bus.req = '0;
        tick();
        checks++; if (bus.grant !== 4'b0000) begin errors++; $display("[TB] FAIL rot_release got %b want 0000", bus.grant); end
    endtask

    task automatic test_req_drop();
        int w;
        int drop_t;
        logic [NREQ-1:0] g, eg;
        logic eb;
        drop_t = PERIOD + 5;
        bus.req = 4'b0001 << $urandom_range(0, NREQ - 1);
        w = rr_pick(bus.req);
        g = 4'b0001 << w;
        last_idx = w;
        tick();
        for (int t = 0; t <= drop_t + 20; t++) begin
            eg = (t <= drop_t) ? g : 4'b0000;
            eb = (t <= drop_t) ? exp_buzz(t) : 1'b0;
            checks++; if (bus.grant !== eg) begin errors++; $display("[TB] FAIL drop_grant t=%0d got %b want %b", t, bus.grant, eg); end
            checks++; if (bus.busy !== (t <= drop_t)) begin errors++; $display("[TB] FAIL drop_busy t=%0d got %b want %b", t, bus.busy, (t <= drop_t)); end
            checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL drop_done t=%0d got %b want 0", t, bus.done); end
            checks++; if (buzzer !== eb) begin errors++; $display("[TB] FAIL drop_buzzer t=%0d got %b want %b", t, buzzer, eb); end
            if (t == drop_t) bus.req = '0;
            tick();
        end
    endtask

    task automatic test_stop_in_off();
        int w;
        int stop_t;
        logic [NREQ-1:0] g, eg;
        logic eb;
        stop_t = PERIOD - 1;   // last OFF cycle of the first beep, its beat tick
        bus.req = 4'b0001 << $urandom_range(0, NREQ - 1);
        w = rr_pick(bus.req);
        g = 4'b0001 << w;
        last_idx = w;
        tick();
        for (int t = 0; t <= stop_t + 8; t++) begin
            if (t <= stop_t) begin
                eg = g; eb = exp_buzz(t);
            end else if (t == stop_t + 1) begin
                eg = 4'b0000; eb = 1'b0;
            end else begin
                eg = g; eb = exp_buzz(t - stop_t - 2);
            end
            checks++; if (bus.grant !== eg) begin errors++; $display("[TB] FAIL stop_grant t=%0d got %b want %b", t, bus.grant, eg); end
            checks++; if (bus.busy !== (t != stop_t + 1)) begin errors++; $display("[TB] FAIL stop_busy t=%0d got %b want %b", t, bus.busy, (t != stop_t + 1)); end
            checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL stop_done t=%0d got %b want 0", t, bus.done); end
            checks++; if (buzzer !== eb) begin errors++; $display("[TB] FAIL stop_buzzer t=%0d got %b want %b", t, buzzer, eb); end
            if (t == stop_t) bus.stop_all = 1'b1;
            if (t == stop_t + 1) begin
                bus.stop_all = 1'b0;
                w = rr_pick(bus.req);
                last_idx = w;
            end
            if (t == stop_t + 8) bus.req = '0;
            tick();
        end
        checks++; if (bus.grant !== 4'b0000) begin errors++; $display("[TB] FAIL stop_release got %b want 0000", bus.grant); end
    endtask

    task automatic test_async_reset();
        int w;
        bus.req = 4'b0001;
        w = rr_pick(bus.req);
        last_idx = w;
        tick(); tick(); tick();
        checks++; if (buzzer !== exp_buzz(2)) begin errors++; $display("[TB] FAIL areset_pre_buzzer got %b want %b", buzzer, exp_buzz(2)); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (buzzer !== 1'b0) begin errors++; $display("[TB] FAIL areset_buzzer got %b want 0", buzzer); end
        checks++; if (bus.grant !== 4'b0000) begin errors++; $display("[TB] FAIL areset_grant got %b want 0000", bus.grant); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL areset_busy got %b want 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL areset_done got %b want 0", bus.done); end
        last_idx = NREQ - 1;
        bus.req = 4'b1000;
        #1 rst_n = 1'b1;
        w = rr_pick(bus.req);
        last_idx = w;
        tick();
        checks++; if (bus.grant !== (4'b0001 << w) || bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL areset_regrant grant %b busy %b want %b 1", bus.grant, bus.busy, 4'b0001 << w); end
        bus.req = '0;
        tick();
        checks++; if (bus.grant !== 4'b0000) begin errors++; $display("[TB] FAIL areset_release got %b want 0000", bus.grant); end
    endtask

    task automatic test_stop_blocks();
        int w;
        rst_n = 1'b0;
        bus.stop_all = 1'b1;
        bus.req = 4'b1111;
        #2 rst_n = 1'b1;
        last_idx = NREQ - 1;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++; if (bus.grant !== 4'b0000 || bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL block_grant i=%0d grant %b busy %b want 0000 0", i, bus.grant, bus.busy); end
        end
        bus.stop_all = 1'b0;
        w = rr_pick(bus.req);
        last_idx = w;
        tick();
        checks++; if (bus.grant !== (4'b0001 << w)) begin errors++; $display("[TB] FAIL block_release_grant got %b want %b", bus.grant, 4'b0001 << w); end
        bus.req = '0;
        tick();
        checks++; if (bus.grant !== 4'b0000) begin errors++; $display("[TB] FAIL block_abort got %b want 0000", bus.grant); end
    endtask

    // Random request patterns; each sequence either completes, loses its
    // owner's request, or is stopped, while other requesters change freely.
    task automatic test_random();
        int w, mode, a;
        logic [NREQ-1:0] g, eg;
        logic ended, eb, ed;
        for (int it = 0; it < 12; it++) begin
            bus.stop_all = 1'b0;
            bus.req = 4'($urandom_range(1, 15));
            w = rr_pick(bus.req);
            g = 4'b0001 << w;
            last_idx = w;
            mode = $urandom_range(0, 2);
            a = $urandom_range(0, SEQ - 1);
            tick();
            for (int t = 0; t <= SEQ + 1; t++) begin
                ended = (mode == 0) ? (t > SEQ) : (t > a);
                eg = ended ? 4'b0000 : g;
                eb = ended ? 1'b0 : exp_buzz(t);
                ed = (mode == 0) && (t == SEQ);
                checks++; if (bus.grant !== eg) begin errors++; $display("[TB] FAIL rnd_grant it=%0d mode=%0d t=%0d got %b want %b", it, mode, t, bus.grant, eg); end
                checks++; if (bus.busy !== !ended) begin errors++; $display("[TB] FAIL rnd_busy it=%0d t=%0d got %b want %b", it, t, bus.busy, !ended); end
                checks++; if (bus.done !== ed) begin errors++; $display("[TB] FAIL rnd_done it=%0d t=%0d got %b want %b", it, t, bus.done, ed); end
                checks++; if (buzzer !== eb) begin errors++; $display("[TB] FAIL rnd_buzzer it=%0d t=%0d got %b want %b", it, t, buzzer, eb); end
                if (ended || (mode == 0 && t == SEQ)) begin
                    bus.req = '0;
                    bus.stop_all = 1'b0;
                end else if (mode == 1 && t == a) begin
                    bus.req = 4'($urandom) & ~g;
                end else if (mode == 2 && t == a) begin
                    bus.stop_all = 1'b1;
                end else begin
                    bus.req = (4'($urandom) & ~g) | g;
                end
                tick();
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        $display("[TB] alarm_sequencer bench start");
        test_reset();
        test_single_cadence();
        test_rotation();
        test_req_drop();
        test_stop_in_off();
        test_async_reset();
        test_stop_blocks();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
